// File: rtl/serv_ibus_encoder.sv
// serv_ibus_encoder: packs host-supplied RV32I fields into instruction words,
// queues them in a FIFO and answers Wishbone instruction fetches from it.
//
// Ports:
//   clk, i_rst_n             clock, synchronous active-low reset
//   i_cmd_*, o_cmd_ready     host push channel (fields in, ready out)
//   o_cmd_err                one-cycle pulse after an illegal-format push
//   i_ibus_adr, i_ibus_cyc   core fetch request
//   o_ibus_rdt, o_ibus_ack   fetched word and one-cycle acknowledge
//   o_fetch_adr              address of the last acknowledged fetch
//   o_count                  FIFO occupancy
//   o_underrun               pulse when a NOP is served from an empty FIFO
module serv_ibus_encoder #(
    parameter int DEPTH     = 4,
    parameter bit EMPTY_NOP = 1'b0
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [2:0]                   i_cmd_fmt,
    input  logic [6:0]                   i_cmd_opcode,
    input  logic [2:0]                   i_cmd_funct3,
    input  logic [6:0]                   i_cmd_funct7,
    input  logic [4:0]                   i_cmd_rd,
    input  logic [4:0]                   i_cmd_rs1,
    input  logic [4:0]                   i_cmd_rs2,
    input  logic [31:0]                  i_cmd_imm,
    output logic                         o_cmd_err,
    input  logic [31:0]                  i_ibus_adr,
    input  logic                         i_ibus_cyc,
    output logic [31:0]                  o_ibus_rdt,
    output logic                         o_ibus_ack,
    output logic [31:0]                  o_fetch_adr,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    st_q, st_d;
    logic [31:0]   rdt_q, rdt_d;
    logic [31:0]   adr_q, adr_d;
    logic          err_q, err_d;
    logic          und_q, und_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        push;
    logic        fifo_empty;
    logic        fetch_data;
    logic        fetch_nop;

    // Field packing; immediate bits outside a format's slots are dropped.
    always_comb begin
        enc_word    = NOP;
        enc_illegal = 1'b0;
        case (i_cmd_fmt)
            FMT_R: enc_word = {i_cmd_funct7, i_cmd_rs2, i_cmd_rs1,
                               i_cmd_funct3, i_cmd_rd, i_cmd_opcode};
            FMT_I: enc_word = {i_cmd_imm[11:0], i_cmd_rs1,
                               i_cmd_funct3, i_cmd_rd, i_cmd_opcode};
            FMT_S: enc_word = {i_cmd_imm[11:5], i_cmd_rs2, i_cmd_rs1,
                               i_cmd_funct3, i_cmd_imm[4:0], i_cmd_opcode};
            FMT_B: enc_word = {i_cmd_imm[12], i_cmd_imm[10:5],
                               i_cmd_rs2, i_cmd_rs1, i_cmd_funct3,
                               i_cmd_imm[4:1], i_cmd_imm[11],
                               i_cmd_opcode};
            FMT_U: enc_word = {i_cmd_imm[31:12], i_cmd_rd, i_cmd_opcode};
            FMT_J: enc_word = {i_cmd_imm[20], i_cmd_imm[10:1],
                               i_cmd_imm[11], i_cmd_imm[19:12],
                               i_cmd_rd, i_cmd_opcode};
            default: begin
                enc_word    = NOP;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Ready ignores any same-cycle pop so a full FIFO never takes a push.
    assign o_cmd_ready = i_rst_n && (count_q != FULL_CNT);
    assign push        = i_cmd_valid && o_cmd_ready;
    assign fifo_empty  = (count_q == '0);

    // Emptiness is judged on the pre-push count.
    assign fetch_data = (st_q == S_IDLE) && i_ibus_cyc && !fifo_empty;
    assign fetch_nop  = (st_q == S_IDLE) && i_ibus_cyc && fifo_empty
                        && EMPTY_NOP;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        st_d     = S_IDLE;
        rdt_d    = rdt_q;
        adr_d    = adr_q;
        err_d    = push && enc_illegal;
        und_d    = fetch_nop;

        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (fetch_data) begin
            rdt_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            adr_d    = i_ibus_adr;
            st_d     = S_ACK;
        end else if (fetch_nop) begin
            rdt_d = NOP;
            adr_d = i_ibus_adr;
            st_d  = S_ACK;
        end

        if (push && !fetch_data) begin
            count_d = count_q + CW'(1);
        end else if (fetch_data && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_q     <= S_IDLE;
            rdt_q    <= '0;
            adr_q    <= '0;
            err_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_q     <= st_d;
            rdt_q    <= rdt_d;
            adr_q    <= adr_d;
            err_q    <= err_d;
            und_q    <= und_d;
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_ibus_ack  = (st_q == S_ACK);
    assign o_ibus_rdt  = rdt_q;
    assign o_fetch_adr = adr_q;
    assign o_count     = count_q;
    assign o_cmd_err   = err_q;
    assign o_underrun  = und_q;

endmodule

// File: tb/tb_serv_ibus_encoder.sv
// Testbench for serv_ibus_encoder: randomized field pushes checked against a
// shift/mask encoder model and a queue model of the FIFO.
module tb_serv_ibus_encoder;

    logic        clk;
    logic        rst_n;
    logic        valid0, valid1;
    logic        cyc0, cyc1;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] adr;

    logic        ready0, ready1;
    logic        err0, err1;
    logic [31:0] rdt0, rdt1;
    logic        ack0, ack1;
    logic [31:0] fadr0, fadr1;
    logic [2:0]  cnt0, cnt1;
    logic        und0, und1;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];

    serv_ibus_encoder #(.DEPTH(4), .EMPTY_NOP(1'b0)) dut0 (
        .clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(valid0), .o_cmd_ready(ready0),
        .i_cmd_fmt(fmt), .i_cmd_opcode(opcode),
        .i_cmd_funct3(f3), .i_cmd_funct7(f7),
        .i_cmd_rd(rd), .i_cmd_rs1(rs1), .i_cmd_rs2(rs2),
        .i_cmd_imm(imm), .o_cmd_err(err0),
        .i_ibus_adr(adr), .i_ibus_cyc(cyc0),
        .o_ibus_rdt(rdt0), .o_ibus_ack(ack0),
        .o_fetch_adr(fadr0), .o_count(cnt0), .o_underrun(und0)
    );

    serv_ibus_encoder #(.DEPTH(4), .EMPTY_NOP(1'b1)) dut1 (
        .clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(valid1), .o_cmd_ready(ready1),
        .i_cmd_fmt(fmt), .i_cmd_opcode(opcode),
        .i_cmd_funct3(f3), .i_cmd_funct7(f7),
        .i_cmd_rd(rd), .i_cmd_rs1(rs1), .i_cmd_rs2(rs2),
        .i_cmd_imm(imm), .o_cmd_err(err1),
        .i_ibus_adr(adr), .i_ibus_cyc(cyc1),
        .o_ibus_rdt(rdt1), .o_ibus_ack(ack1),
        .o_fetch_adr(fadr1), .o_count(cnt1), .o_underrun(und1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: places each field at its bit offset arithmetically.
    function automatic logic [31:0] ref_encode(
        bit [31:0] fm, bit [31:0] op, bit [31:0] fn3, bit [31:0] fn7,
        bit [31:0] d, bit [31:0] s1, bit [31:0] s2, bit [31:0] u);
        bit [31:0] base;
        base = op | (fn3 << 12);
        case (fm)
            0: return base | (d << 7) | (s1 << 15) | (s2 << 20) | (fn7 << 25);
            1: return base | (d << 7) | (s1 << 15) | ((u & 32'hFFF) << 20);
            2: return base | ((u & 32'h1F) << 7) | (s1 << 15) | (s2 << 20)
                      | (((u >> 5) & 32'h7F) << 25);
            3: return base | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hF) << 8)
                      | (s1 << 15) | (s2 << 20)
                      | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 1) << 31);
            4: return op | (d << 7) | (u & 32'hFFFFF000);
            5: return op | (d << 7) | (((u >> 12) & 32'hFF) << 12)
                      | (((u >> 11) & 1) << 20) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 20) & 1) << 31);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic [31:0] exp_word();
        return ref_encode(fmt, opcode, f3, f7, rd, rs1, rs2, imm);
    endfunction

    task automatic set_cmd(input logic [2:0] fm, input logic [6:0] op,
                           input logic [2:0] fn3, input logic [6:0] fn7,
                           input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] u);
        fmt = fm; opcode = op; f3 = fn3; f7 = fn7;
        rd = d; rs1 = s1; rs2 = s2; imm = u;
    endtask

    task automatic rand_cmd();
        set_cmd(3'($urandom_range(0, 5)), 7'($urandom), 3'($urandom),
                7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom);
    endtask

    // Called just after a negedge; pushes current fields into dut0.
    task automatic do_push();
        valid0 = 1'b1;
        if (ready0) q.push_back(exp_word());
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    // Raises cyc on dut0 and waits (bounded) for the acknowledge.
    task automatic do_fetch(output logic [31:0] w, output bit got);
        adr = $urandom;
        cyc0 = 1'b1;
        got = 1'b0;
        w = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ack0) begin
                got = 1'b1;
                w = rdt0;
            end
        end
        cyc0 = 1'b0;
    endtask

    task automatic fetch_and_check(input string name);
        logic [31:0] w;
        logic [31:0] e;
        bit got;
        do_fetch(w, got);
        e = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no ack within bound, expected word %h", name, e);
        end else if (w !== e) begin
            errors++;
            $display("FAIL %s: rdt got %h expected %h", name, w, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ready0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack0, err0, und0, cnt0} !== 6'b0 || rdt0 !== 0 || fadr0 !== 0) begin
            errors++;
            $display("FAIL reset_state: ack=%b err=%b und=%b cnt=%0d rdt=%h adr=%h expected all 0",
                     ack0, err0, und0, cnt0, rdt0, fadr0);
        end
        checks++;
        if (ready0 !== 1'b1 || cnt1 !== 0) begin
            errors++;
            $display("FAIL reset_ready_after: ready=%b cnt1=%0d expected 1/0", ready0, cnt1);
        end
    endtask

    task automatic test_addi();
        logic [31:0] w;
        bit got;
        set_cmd(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        do_push();
        checks++;
        if (cnt0 !== 3'd1) begin
            errors++;
            $display("FAIL addi_count: got %0d expected 1", cnt0);
        end
        do_fetch(w, got);
        void'(q.pop_front());
        checks++;
        if (!got || w !== 32'h0050_0093) begin
            errors++;
            $display("FAIL addi_rdt: got %h (ack=%b) expected 00500093", w, got);
        end
        checks++;
        if (fadr0 !== adr) begin
            errors++;
            $display("FAIL addi_adr: got %h expected %h", fadr0, adr);
        end
        checks++;
        if (cnt0 !== 3'd0) begin
            errors++;
            $display("FAIL addi_count_after: got %0d expected 0", cnt0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[2];
        bit prev;
        int n_ack;
        int first_idx;
        exp_w[0] = 32'h0020_A423;
        exp_w[1] = 32'hFE00_0EE3;
        set_cmd(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        do_push();
        set_cmd(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
        do_push();
        q.delete();
        prev = 1'b0;
        n_ack = 0;
        first_idx = -1;
        cyc0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0 && prev) begin
                errors++;
                $display("FAIL b2b_gap: ack high on consecutive cycles at %0d", i);
            end
            if (ack0) begin
                if (first_idx < 0) first_idx = i;
                checks++;
                if (n_ack > 1 || rdt0 !== exp_w[n_ack > 1 ? 1 : n_ack]) begin
                    errors++;
                    $display("FAIL b2b_rdt: ack %0d rdt %h expected %h",
                             n_ack, rdt0, exp_w[n_ack > 1 ? 1 : n_ack]);
                end
                n_ack++;
            end
            prev = ack0;
        end
        cyc0 = 1'b0;
        checks++;
        if (n_ack != 2 || first_idx != 0) begin
            errors++;
            $display("FAIL b2b_count: acks %0d first at %0d expected 2 at 0",
                     n_ack, first_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_j_u();
        set_cmd(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        do_push();
        set_cmd(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        do_push();
        checks++;
        if (q[0] !== 32'h0080_00EF || q[1] !== 32'h1234_52B7) begin
            errors++;
            $display("FAIL ju_model: model %h %h expected 008000EF 123452B7",
                     q[0], q[1]);
        end
        fetch_and_check("ju_j");
        fetch_and_check("ju_u");
    endtask

    task automatic test_fill_wrap();
        logic [31:0] w5;
        for (int i = 0; i < 4; i++) begin
            rand_cmd();
            do_push();
        end
        checks++;
        if (cnt0 !== 3'd4 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d ready=%b expected 4/0", cnt0, ready0);
        end
        rand_cmd();
        w5 = exp_word();
        valid0 = 1'b1;
        adr = $urandom;
        cyc0 = 1'b1;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdt0 !== q[0] || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL fill_pop: ack=%b rdt=%h ready=%b expected 1/%h/1",
                     ack0, rdt0, ready0, q[0]);
        end
        void'(q.pop_front());
        cyc0 = 1'b0;
        @(negedge clk);
        valid0 = 1'b0;
        q.push_back(w5);
        checks++;
        if (cnt0 !== 3'd4) begin
            errors++;
            $display("FAIL fill_pending: cnt=%0d expected 4", cnt0);
        end
        for (int i = 0; i < 4; i++) fetch_and_check("fill_drain");
        for (int i = 0; i < 2; i++) begin
            rand_cmd();
            do_push();
        end
        for (int i = 0; i < 8; i++) begin
            rand_cmd();
            do_push();
            fetch_and_check("wrap_order");
        end
        fetch_and_check("wrap_tail0");
        fetch_and_check("wrap_tail1");
        checks++;
        if (cnt0 !== 3'd0) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 0", cnt0);
        end
    endtask

    task automatic test_illegal();
        for (int k = 6; k < 8; k++) begin
            set_cmd(3'(k), 7'($urandom), 3'($urandom), 7'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            do_push();
            checks++;
            if (err0 !== 1'b1) begin
                errors++;
                $display("FAIL illegal_err: fmt %0d err=%b expected 1", k, err0);
            end
            @(negedge clk);
            checks++;
            if (err0 !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse: err=%b expected 0", err0);
            end
            fetch_and_check("illegal_nop");
        end
    endtask

    task automatic test_empty_wait();
        logic [31:0] w;
        adr = $urandom;
        cyc0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 1'b0) begin
                errors++;
                $display("FAIL empty_wait: ack=%b expected 0", ack0);
            end
        end
        rand_cmd();
        w = exp_word();
        valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        checks++;
        if (ack0 !== 1'b0) begin
            errors++;
            $display("FAIL empty_early: ack=%b expected 0", ack0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdt0 !== w) begin
            errors++;
            $display("FAIL empty_late: ack=%b rdt=%h expected 1/%h", ack0, rdt0, w);
        end
        cyc0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_underrun();
        logic [31:0] w;
        cyc1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || rdt1 !== 32'h13 || und1 !== 1'b1) begin
            errors++;
            $display("FAIL underrun_nop: ack=%b rdt=%h und=%b expected 1/00000013/1",
                     ack1, rdt1, und1);
        end
        cyc1 = 1'b0;
        @(negedge clk);
        checks++;
        if (und1 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pulse: und=%b ack=%b expected 0/0", und1, ack1);
        end
        rand_cmd();
        w = exp_word();
        valid1 = 1'b1;
        cyc1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        cyc1 = 1'b0;
        checks++;
        if (ack1 !== 1'b1 || rdt1 !== 32'h13 || cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL underrun_coincide: ack=%b rdt=%h cnt=%0d expected 1/00000013/1",
                     ack1, rdt1, cnt1);
        end
        @(negedge clk);
        cyc1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || rdt1 !== w || und1 !== 1'b0) begin
            errors++;
            $display("FAIL underrun_queued: ack=%b rdt=%h und=%b expected 1/%h/0",
                     ack1, rdt1, und1, w);
        end
        cyc1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_during_ack();
        bit got;
        for (int i = 0; i < 2; i++) begin
            rand_cmd();
            do_push();
        end
        adr = $urandom;
        cyc0 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = ack0;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_ack_seen: no ack within bound");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b0 || cnt0 !== 3'd0) begin
            errors++;
            $display("FAIL rst_during_ack: ack=%b cnt=%0d expected 0/0", ack0, cnt0);
        end
        rst_n = 1'b1;
        cyc0 = 1'b0;
        q.delete();
        @(negedge clk);
        checks++;
        if (cnt0 !== 3'd0 || ready0 !== 1'b1 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover: cnt=%0d ready=%b ack=%b expected 0/1/0",
                     cnt0, ready0, ack0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        cyc0 = 1'b0;
        cyc1 = 1'b0;
        adr = '0;
        set_cmd(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_addi();
        test_back_to_back();
        test_j_u();
        test_fill_wrap();
        test_illegal();
        test_empty_wait();
        test_underrun();
        test_reset_during_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
